// File: rtl/conv_kernel_ctrl.sv
// Per-frame column sequencer feeding the 5x5 kernel window datapath: scans x/y,
// generates per-lane push enables and tags the pushes that complete a window.
module conv_kernel_ctrl #(
  parameter int KERNEL_DIAMETER_N = 5,
  parameter int PIXEL_W           = 8,
  parameter int IMG_W_MAX         = 1024,
  parameter int IMG_H_MAX         = 1024
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start_i,
  input  logic [$clog2(IMG_W_MAX):0]                      cfg_w_i,
  input  logic [$clog2(IMG_H_MAX):0]                      cfg_h_i,
  output logic                                            busy_o,
  output logic                                            done_o,
  output logic                                            err_o,
  input  logic                                            col_vld_i,
  output logic                                            col_rdy_o,
  input  logic [KERNEL_DIAMETER_N*PIXEL_W-1:0]            col_dat_i,
  input  logic                                            stall_i,
  output logic [KERNEL_DIAMETER_N-1:0]                    colD_push_o,
  output logic [KERNEL_DIAMETER_N*PIXEL_W-1:0]            colD_dat_o,
  output logic                                            colD_pos_vld_o,
  output logic [$clog2(IMG_W_MAX)+$clog2(IMG_H_MAX)-1:0]  colD_pos_o
);

  localparam int K   = KERNEL_DIAMETER_N;
  localparam int X_W = $clog2(IMG_W_MAX);
  localparam int Y_W = $clog2(IMG_H_MAX);
  localparam int D_W = K * PIXEL_W;

  localparam logic [X_W:0]   W_MIN  = (X_W+1)'(K);
  localparam logic [X_W:0]   W_MAX  = (X_W+1)'(IMG_W_MAX);
  localparam logic [Y_W:0]   H_MIN  = (Y_W+1)'(K);
  localparam logic [Y_W:0]   H_MAX  = (Y_W+1)'(IMG_H_MAX);
  localparam logic [X_W-1:0] X_EDGE = X_W'(K-1);
  localparam logic [Y_W-1:0] Y_EDGE = Y_W'(K-1);
  localparam logic [X_W-1:0] X_HALF = X_W'((K-1)/2);
  localparam logic [Y_W-1:0] Y_HALF = Y_W'((K-1)/2);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t             state_q, state_d;
  logic [X_W:0]       w_q;
  logic [Y_W:0]       h_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic               err_q;
  logic [K-1:0]       push_q;
  logic [D_W-1:0]     dat_q;
  logic               pos_vld_q;
  logic [X_W+Y_W-1:0] pos_q;

  logic               cfg_ok;
  logic               start_ok;
  logic               acc;
  logic               x_last;
  logic               y_last;
  logic               win_vld;
  logic [K-1:0]       push_mask;

  always_comb begin
    cfg_ok   = (cfg_w_i >= W_MIN) && (cfg_w_i <= W_MAX) &&
               (cfg_h_i >= H_MIN) && (cfg_h_i <= H_MAX);
    start_ok = (state_q == IDLE) && start_i && cfg_ok;
    acc      = (state_q == ACTIVE) && col_vld_i && !stall_i;
    x_last   = ({1'b0, x_q} == (w_q - (X_W+1)'(1)));
    y_last   = ({1'b0, y_q} == (h_q - (Y_W+1)'(1)));
    win_vld  = (x_q >= X_EDGE) && (y_q >= Y_EDGE);
    // Lane n carries row y-(K-1-n); rows above the frame top stay unpushed.
    push_mask = '0;
    for (int n = 0; n < K; n++) begin
      push_mask[n] = (({1'b0, y_q} + (Y_W+1)'(n)) >= (Y_W+1)'(K-1));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = ACTIVE;
      ACTIVE:  if (acc && x_last && y_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      err_q     <= 1'b0;
      push_q    <= '0;
      dat_q     <= '0;
      pos_vld_q <= 1'b0;
      pos_q     <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= (state_q == IDLE) && start_i && !cfg_ok;
      push_q    <= acc ? push_mask : '0;
      pos_vld_q <= acc && win_vld;
      if (start_ok) begin
        w_q <= cfg_w_i;
        h_q <= cfg_h_i;
        x_q <= '0;
        y_q <= '0;
      end else if (acc) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= y_q + Y_W'(1);
        end else begin
          x_q <= x_q + X_W'(1);
        end
      end
      if (acc) dat_q <= col_dat_i;
      // Centre tag only moves for complete windows, so the subtraction never underflows.
      if (acc && win_vld) pos_q <= {y_q - Y_HALF, x_q - X_HALF};
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign err_o          = err_q;
  assign col_rdy_o      = (state_q == ACTIVE) && !stall_i;
  assign colD_push_o    = push_q;
  assign colD_dat_o     = dat_q;
  assign colD_pos_vld_o = pos_vld_q;
  assign colD_pos_o     = pos_q;

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// Directed self-checking bench for conv_kernel_ctrl: frame scans, backpressure,
// configuration errors, reset abort and back-to-back starts.
module tb_conv_kernel_ctrl;

  localparam int K  = 5;
  localparam int PW = 8;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int DW = K * PW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [XW:0]      cfg_w_i = '0;
  logic [YW:0]      cfg_h_i = '0;
  logic             busy_o, done_o, err_o;
  logic             col_vld_i = 1'b0;
  logic             col_rdy_o;
  logic [DW-1:0]    col_dat_i = '0;
  logic             stall_i = 1'b0;
  logic [K-1:0]     colD_push_o;
  logic [DW-1:0]    colD_dat_o;
  logic             colD_pos_vld_o;
  logic [XW+YW-1:0] colD_pos_o;

  conv_kernel_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_w_i(cfg_w_i), .cfg_h_i(cfg_h_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .col_vld_i(col_vld_i), .col_rdy_o(col_rdy_o), .col_dat_i(col_dat_i), .stall_i(stall_i),
    .colD_push_o(colD_push_o), .colD_dat_o(colD_dat_o),
    .colD_pos_vld_o(colD_pos_vld_o), .colD_pos_o(colD_pos_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations captured by drive_frame for the scenario tasks to judge.
  logic [K-1:0]     push_obs[$];
  logic [XW+YW-1:0] pos_obs[$];
  logic [XW+YW-1:0] pos_exp[$];
  logic [DW-1:0]    dat_obs[$];
  logic [DW-1:0]    dat_exp[$];
  int accepts, rdy_viol, done_idx, last_push_idx, last_pos_idx;
  bit timed_out, rdy_in_done, busy_after;

  function automatic logic [K-1:0] row_mask(input int row);
    logic [K-1:0] m;
    for (int n = 0; n < K; n++) m[n] = ((row + n) >= (K - 1));
    return m;
  endfunction

  function automatic logic [XW+YW-1:0] pos_of(input int y, input int x);
    return {YW'(y), XW'(x)};
  endfunction

  task automatic build_pos_exp(input int w, input int h);
    pos_exp.delete();
    for (int y = K - 1; y < h; y++)
      for (int x = K - 1; x < w; x++)
        pos_exp.push_back(pos_of(y - (K-1)/2, x - (K-1)/2));
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    col_vld_i = 1'b0;
    stall_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a frame, feeds columns until done_o, recording what the DUT emits.
  task automatic drive_frame(input int w, input int h, input bit stall_mode,
                             input bit hold_start, input int mid_w, input int mid_h);
    push_obs.delete(); pos_obs.delete(); dat_obs.delete(); dat_exp.delete();
    accepts = 0; rdy_viol = 0; done_idx = -1; last_push_idx = -2; last_pos_idx = -3;
    timed_out = 1'b1;
    @(negedge clk);
    start_i = 1'b1; cfg_w_i = (XW+1)'(w); cfg_h_i = (YW+1)'(h);
    col_vld_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    start_i = hold_start; cfg_w_i = (XW+1)'(mid_w); cfg_h_i = (YW+1)'(mid_h);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stall_i   = stall_mode && ((cyc % 2) == 1);
      col_vld_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      col_dat_i = DW'({$urandom(), $urandom()});
      #1;
      if (stall_i && col_rdy_o) rdy_viol++;
      if (col_vld_i && col_rdy_o) begin
        accepts++;
        dat_exp.push_back(col_dat_i);
      end
      @(negedge clk);
      if (colD_push_o != '0) begin
        push_obs.push_back(colD_push_o);
        dat_obs.push_back(colD_dat_o);
        last_push_idx = cyc;
      end
      if (colD_pos_vld_o) begin
        pos_obs.push_back(colD_pos_o);
        last_pos_idx = cyc;
      end
      if (done_o) begin
        done_idx = cyc;
        timed_out = 1'b0;
        break;
      end
    end
    n_checks++;
    if (timed_out) begin
      n_fail++;
      $display("[TB] FAIL frame_timeout: done_o not seen, got accepts=%0d required %0d", accepts, w*h);
    end
    stall_i = 1'b0;
    #1;
    rdy_in_done = col_rdy_o;
    col_vld_i = 1'b0;
    @(negedge clk);
    busy_after = busy_o;
  endtask

  task automatic test_reset;
    // Valid start held during reset must not launch a frame.
    start_i = 1'b1; cfg_w_i = 11'd5; cfg_h_i = 11'd5;
    col_vld_i = 1'b1; col_dat_i = '1;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b required 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b required 0", done_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b required 0", err_o); end
    n_checks++; if (col_rdy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rdy: got %b required 0", col_rdy_o); end
    n_checks++; if (colD_push_o !== '0) begin n_fail++; $display("[TB] FAIL reset_push: got %b required 0", colD_push_o); end
    n_checks++; if (colD_pos_vld_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pos_vld: got %b required 0", colD_pos_vld_o); end
    n_checks++; if (colD_dat_o !== '0) begin n_fail++; $display("[TB] FAIL reset_dat: got %h required 0", colD_dat_o); end
    n_checks++; if (colD_pos_o !== '0) begin n_fail++; $display("[TB] FAIL reset_pos: got %h required 0", colD_pos_o); end
    start_i = 1'b0; col_vld_i = 1'b0; col_dat_i = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_minimal_frame;
    logic [K-1:0] row_tab [5];
    row_tab = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};
    drive_frame(5, 5, 1'b0, 1'b0, 5, 5);
    n_checks++; if (accepts != 25) begin n_fail++; $display("[TB] FAIL min_accepts: got %0d required 25", accepts); end
    n_checks++; if (push_obs.size() != 25) begin n_fail++; $display("[TB] FAIL min_push_count: got %0d required 25", push_obs.size()); end
    for (int i = 0; i < push_obs.size() && i < 25; i++) begin
      n_checks++;
      if (push_obs[i] !== row_tab[i/5]) begin
        n_fail++; $display("[TB] FAIL min_mask[%0d]: got %b required %b", i, push_obs[i], row_tab[i/5]);
      end
    end
    n_checks++; if (pos_obs.size() != 1) begin n_fail++; $display("[TB] FAIL min_pos_count: got %0d required 1", pos_obs.size()); end
    if (pos_obs.size() >= 1) begin
      n_checks++; if (pos_obs[0] !== 20'h00802) begin n_fail++; $display("[TB] FAIL min_pos: got %h required 00802", pos_obs[0]); end
    end
    n_checks++; if (last_pos_idx != done_idx) begin n_fail++; $display("[TB] FAIL min_pos_vs_done: got pos cycle %0d required done cycle %0d", last_pos_idx, done_idx); end
    n_checks++; if (last_push_idx != done_idx) begin n_fail++; $display("[TB] FAIL min_push_vs_done: got push cycle %0d required done cycle %0d", last_push_idx, done_idx); end
    n_checks++; if (dat_obs.size() != dat_exp.size()) begin n_fail++; $display("[TB] FAIL min_dat_count: got %0d required %0d", dat_obs.size(), dat_exp.size()); end
    for (int i = 0; i < dat_obs.size() && i < dat_exp.size(); i++) begin
      n_checks++;
      if (dat_obs[i] !== dat_exp[i]) begin n_fail++; $display("[TB] FAIL min_dat[%0d]: got %h required %h", i, dat_obs[i], dat_exp[i]); end
    end
    n_checks++; if (rdy_in_done !== 1'b0) begin n_fail++; $display("[TB] FAIL min_rdy_in_done: got %b required 0", rdy_in_done); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("[TB] FAIL min_busy_after: got %b required 0", busy_after); end
  endtask

  task automatic test_full_scan;
    drive_frame(8, 6, 1'b0, 1'b0, 8, 6);
    build_pos_exp(8, 6);
    n_checks++; if (accepts != 48) begin n_fail++; $display("[TB] FAIL scan_accepts: got %0d required 48", accepts); end
    n_checks++; if (pos_obs.size() != 8) begin n_fail++; $display("[TB] FAIL scan_pos_count: got %0d required 8", pos_obs.size()); end
    for (int i = 0; i < pos_obs.size() && i < pos_exp.size(); i++) begin
      n_checks++;
      if (pos_obs[i] !== pos_exp[i]) begin n_fail++; $display("[TB] FAIL scan_pos[%0d]: got %h required %h", i, pos_obs[i], pos_exp[i]); end
    end
    for (int i = 0; i < push_obs.size() && i < 48; i++) begin
      n_checks++;
      if (push_obs[i] !== row_mask(i/8)) begin n_fail++; $display("[TB] FAIL scan_mask[%0d]: got %b required %b", i, push_obs[i], row_mask(i/8)); end
    end
    n_checks++; if (last_push_idx != done_idx) begin n_fail++; $display("[TB] FAIL scan_push_vs_done: got %0d required %0d", last_push_idx, done_idx); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("[TB] FAIL scan_busy_after: got %b required 0", busy_after); end
  endtask

  task automatic test_backpressure;
    drive_frame(6, 5, 1'b1, 1'b0, 6, 5);
    build_pos_exp(6, 5);
    n_checks++; if (rdy_viol != 0) begin n_fail++; $display("[TB] FAIL bp_rdy_while_stall: got %0d cycles required 0", rdy_viol); end
    n_checks++; if (accepts != 30) begin n_fail++; $display("[TB] FAIL bp_accepts: got %0d required 30", accepts); end
    n_checks++; if (push_obs.size() != 30) begin n_fail++; $display("[TB] FAIL bp_push_count: got %0d required 30", push_obs.size()); end
    for (int i = 0; i < push_obs.size() && i < 30; i++) begin
      n_checks++;
      if (push_obs[i] !== row_mask(i/6)) begin n_fail++; $display("[TB] FAIL bp_mask[%0d]: got %b required %b", i, push_obs[i], row_mask(i/6)); end
    end
    n_checks++; if (pos_obs.size() != 2) begin n_fail++; $display("[TB] FAIL bp_pos_count: got %0d required 2", pos_obs.size()); end
    for (int i = 0; i < pos_obs.size() && i < pos_exp.size(); i++) begin
      n_checks++;
      if (pos_obs[i] !== pos_exp[i]) begin n_fail++; $display("[TB] FAIL bp_pos[%0d]: got %h required %h", i, pos_obs[i], pos_exp[i]); end
    end
    for (int i = 0; i < dat_obs.size() && i < dat_exp.size(); i++) begin
      n_checks++;
      if (dat_obs[i] !== dat_exp[i]) begin n_fail++; $display("[TB] FAIL bp_dat[%0d]: got %h required %h", i, dat_obs[i], dat_exp[i]); end
    end
  endtask

  task automatic test_config_error;
    int bad_w [2];
    int bad_h [2];
    bad_w = '{4, 5};
    bad_h = '{10, 1025};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start_i = 1'b1; cfg_w_i = (XW+1)'(bad_w[t]); cfg_h_i = (YW+1)'(bad_h[t]);
      @(negedge clk);
      start_i = 1'b0;
      n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL cfg_err_pulse[%0d]: got %b required 1", t, err_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL cfg_err_busy[%0d]: got %b required 0", t, busy_o); end
      @(negedge clk);
      n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL cfg_err_clear[%0d]: got %b required 0", t, err_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL cfg_err_idle[%0d]: got %b required 0", t, busy_o); end
    end
    // Largest legal frame is accepted.
    @(negedge clk);
    start_i = 1'b1; cfg_w_i = 11'd1024; cfg_h_i = 11'd1024;
    @(negedge clk);
    start_i = 1'b0;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL cfg_max_err: got %b required 0", err_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL cfg_max_busy: got %b required 1", busy_o); end
    apply_reset();
  endtask

  task automatic test_start_while_busy;
    drive_frame(8, 6, 1'b0, 1'b1, 5, 5);
    start_i = 1'b0;
    build_pos_exp(8, 6);
    n_checks++; if (accepts != 48) begin n_fail++; $display("[TB] FAIL busy_start_accepts: got %0d required 48", accepts); end
    n_checks++; if (pos_obs.size() != 8) begin n_fail++; $display("[TB] FAIL busy_start_pos_count: got %0d required 8", pos_obs.size()); end
    if (pos_obs.size() == 8) begin
      n_checks++; if (pos_obs[7] !== pos_exp[7]) begin n_fail++; $display("[TB] FAIL busy_start_last_pos: got %h required %h", pos_obs[7], pos_exp[7]); end
    end
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_start_idle: got %b required 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_start_extra_done: got %b required 0", done_o); end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    start_i = 1'b1; cfg_w_i = 11'd8; cfg_h_i = 11'd6;
    @(negedge clk);
    start_i = 1'b0; col_vld_i = 1'b1;
    // 19 accepts leave the scan at x=3, y=2.
    for (int i = 0; i < 19; i++) begin
      col_dat_i = DW'({$urandom(), $urandom()}) | DW'(1);
      @(negedge clk);
    end
    n_checks++; if (colD_push_o !== 5'b11100) begin n_fail++; $display("[TB] FAIL mid_pre_mask: got %b required 11100", colD_push_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre_busy: got %b required 1", busy_o); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy: got %b required 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_done: got %b required 0", done_o); end
    n_checks++; if (col_rdy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rdy: got %b required 0", col_rdy_o); end
    n_checks++; if (colD_push_o !== '0) begin n_fail++; $display("[TB] FAIL mid_push: got %b required 0", colD_push_o); end
    n_checks++; if (colD_pos_vld_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_pos_vld: got %b required 0", colD_pos_vld_o); end
    n_checks++; if (colD_dat_o !== '0) begin n_fail++; $display("[TB] FAIL mid_dat: got %h required 0", colD_dat_o); end
    n_checks++; if (colD_pos_o !== '0) begin n_fail++; $display("[TB] FAIL mid_pos: got %h required 0", colD_pos_o); end
    rst = 1'b0; col_vld_i = 1'b0;
    drive_frame(5, 5, 1'b0, 1'b0, 5, 5);
    n_checks++; if (accepts != 25) begin n_fail++; $display("[TB] FAIL mid_next_accepts: got %0d required 25", accepts); end
    n_checks++; if (pos_obs.size() != 1) begin n_fail++; $display("[TB] FAIL mid_next_pos_count: got %0d required 1", pos_obs.size()); end
    if (pos_obs.size() == 1) begin
      n_checks++; if (pos_obs[0] !== 20'h00802) begin n_fail++; $display("[TB] FAIL mid_next_pos: got %h required 00802", pos_obs[0]); end
    end
  endtask

  task automatic test_back_to_back;
    drive_frame(5, 5, 1'b0, 1'b1, 5, 5);
    n_checks++; if (accepts != 25) begin n_fail++; $display("[TB] FAIL b2b_accepts: got %0d required 25", accepts); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_gap: got %b required 0", busy_after); end
    col_vld_i = 1'b1;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_restart: got %b required 1", busy_o); end
    n_checks++; if (colD_push_o !== '0) begin n_fail++; $display("[TB] FAIL b2b_no_early_push: got %b required 0", colD_push_o); end
    @(negedge clk);
    n_checks++; if (colD_push_o !== 5'b10000) begin n_fail++; $display("[TB] FAIL b2b_first_mask: got %b required 10000", colD_push_o); end
    n_checks++; if (colD_pos_vld_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_first_pos_vld: got %b required 0", colD_pos_vld_o); end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_minimal_frame();
    test_full_scan();
    test_backpressure();
    test_config_error();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
